// File: rtl/multi_phase_traffic_ctrl.sv
// Multi-phase traffic signal controller with demand-skipping phase rotation.
// Night flash mode is compiled in when TC_NIGHT_FLASH_EN is defined.
module multi_phase_traffic_ctrl #(
    parameter int NUM_PHASES  = 4,
    parameter int CNT_W       = 8,
    parameter int GREEN_TIME  = 60,
    parameter int YELLOW_TIME = 4,
    parameter int RED_TIME    = 3,
    parameter int SAFE_TIME   = 15,
    localparam int PW = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  tick,
    input  logic [NUM_PHASES-1:0] demand,
    input  logic                  flash,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] red,
    output logic [PW-1:0]         phase_idx,
    output logic                  all_red
);

    typedef enum logic [2:0] {
        S_SAFE,
        S_GREEN,
        S_YELLOW,
        S_ALLRED,
        S_FLASH
    } state_t;

    // Counter load value: duration truncated to CNT_W, zero treated as one.
    function automatic logic [CNT_W-1:0] load_val(input int t);
        logic [CNT_W-1:0] tt;
        tt = CNT_W'(t);
        return (tt == '0) ? '0 : tt - CNT_W'(1);
    endfunction

    localparam logic [CNT_W-1:0] SAFE_LD   = load_val(SAFE_TIME);
    localparam logic [CNT_W-1:0] GREEN_LD  = load_val(GREEN_TIME);
    localparam logic [CNT_W-1:0] YELLOW_LD = load_val(YELLOW_TIME);
    localparam logic [CNT_W-1:0] RED_LD    = load_val(RED_TIME);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [NUM_PHASES-1:0]   lat_q, lat_d;
    logic [NUM_PHASES-1:0]   sel;
    logic [PW-1:0]           nxt_phase;
    logic [PW-1:0]           tgt;
    logic                    go_green;
    logic                    found;
    int                      idx;

`ifdef TC_NIGHT_FLASH_EN
    logic tog_q, tog_d;
`else
    logic unused_flash;
    assign unused_flash = flash;
`endif

    assign sel       = NUM_PHASES'(1) << phase_q;
    assign phase_idx = phase_q;

    // First latched phase after the current one, else plain rotation.
    always_comb begin
        nxt_phase = PW'((int'(phase_q) + 1) % NUM_PHASES);
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k < NUM_PHASES; k++) begin
            idx = (int'(phase_q) + k) % NUM_PHASES;
            if (!found && lat_q[PW'(idx)]) begin
                found     = 1'b1;
                nxt_phase = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        go_green = 1'b0;
        tgt      = '0;
        lat_d    = lat_q | demand;
`ifdef TC_NIGHT_FLASH_EN
        tog_d    = tog_q;
`endif
        if (state_q == S_GREEN) begin
            lat_d = lat_d & ~sel;
        end
        if (tick) begin
            if (cnt_q != '0 && state_q != S_FLASH) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                case (state_q)
                    S_SAFE: begin
                        go_green = 1'b1;
                    end
                    S_GREEN: begin
                        state_d = S_YELLOW;
                        cnt_d   = YELLOW_LD;
                    end
                    S_YELLOW: begin
                        state_d = S_ALLRED;
                        cnt_d   = RED_LD;
                    end
                    S_ALLRED: begin
`ifdef TC_NIGHT_FLASH_EN
                        if (flash) begin
                            state_d = S_FLASH;
                            tog_d   = 1'b0;
                        end else begin
                            go_green = 1'b1;
                            tgt      = nxt_phase;
                        end
`else
                        go_green = 1'b1;
                        tgt      = nxt_phase;
`endif
                    end
`ifdef TC_NIGHT_FLASH_EN
                    S_FLASH: begin
                        if (flash) begin
                            tog_d = ~tog_q;
                        end else begin
                            state_d = S_SAFE;
                            cnt_d   = SAFE_LD;
                            tog_d   = 1'b0;
                        end
                    end
`endif
                    default: begin
                        state_d = S_SAFE;
                        cnt_d   = SAFE_LD;
                    end
                endcase
            end
        end
        // Entering green clears that phase's latch; clear beats a new set.
        if (go_green) begin
            state_d = S_GREEN;
            cnt_d   = GREEN_LD;
            phase_d = tgt;
            lat_d   = lat_d & ~(NUM_PHASES'(1) << tgt);
        end
    end

    always_comb begin
        green   = '0;
        yellow  = '0;
        red     = '1;
        all_red = 1'b0;
        unique case (1'b1)
            (state_q == S_GREEN): begin
                green = sel;
                red   = ~sel;
            end
            (state_q == S_YELLOW): begin
                yellow = sel;
                red    = ~sel;
            end
`ifdef TC_NIGHT_FLASH_EN
            (state_q == S_FLASH): begin
                red     = '0;
                yellow  = {NUM_PHASES{tog_q}};
                all_red = 1'b1;
            end
`endif
            default: begin
                all_red = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_SAFE;
            cnt_q   <= SAFE_LD;
            phase_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            lat_q   <= lat_d;
        end
    end

`ifdef TC_NIGHT_FLASH_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tog_q <= 1'b0;
        end else begin
            tog_q <= tog_d;
        end
    end
`endif

endmodule
